// File: rtl/c1541_track_sched.sv
// c1541_track_sched: sequences the SD block reads and writes that load a D64 track
// into the GCR track buffer and write a modified track back before the head moves on.
module c1541_track_sched #(
    parameter int MAX_TRACK = 40,
    parameter int SETTLE    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic        img_present,
    input  logic        img_readonly,
    input  logic [5:0]  track,
    input  logic        buf_we,
    output logic        busy,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic [5:0]  cur_track
);
    localparam int            CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [5:0]    MAX_T    = 6'(MAX_TRACK);

    typedef enum logic [2:0] {IDLE, FLUSH_REQ, FLUSH_WAIT, LOAD_REQ, LOAD_WAIT} state_t;

    state_t        state, state_n;
    logic [4:0]    sec, sec_n;
    logic [5:0]    cur_track_n, load_track, load_track_n, target, track_prev;
    logic [CW-1:0] settle_cnt;
    logic          dirty, dirty_n, mount_pend, mount_pend_n, ack_d;
    logic          sd_rd_n, sd_wr_n;
    logic [31:0]   sd_lba_n;
    logic          settled, ack_fall, abort, target_ok;

    function automatic logic [4:0] nsec(input logic [5:0] t);
        if (t <= 6'd17)      return 5'd21;
        else if (t <= 6'd24) return 5'd19;
        else if (t <= 6'd30) return 5'd18;
        else                 return 5'd17;
    endfunction

    function automatic logic [31:0] base_lba(input logic [5:0] t);
        logic [31:0] tt;
        tt = {26'd0, t};
        if (t <= 6'd17)      return (tt - 32'd1) * 32'd21;
        else if (t <= 6'd24) return 32'd357 + (tt - 32'd18) * 32'd19;
        else if (t <= 6'd30) return 32'd490 + (tt - 32'd25) * 32'd18;
        else                 return 32'd598 + (tt - 32'd31) * 32'd17;
    endfunction

    assign settled   = (settle_cnt == SETTLE_C);
    assign ack_fall  = ack_d & ~sd_ack;
    assign abort     = mount_pend | img_mounted | ~img_present;
    assign target_ok = (target != 6'd0) && (target <= MAX_T);
    assign busy      = (state != IDLE) || (cur_track != target) || (cur_track == 6'd0);

    // target only follows the head after it has rested on one track for SETTLE cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            track_prev <= 6'd0;
            settle_cnt <= '0;
            target     <= 6'd0;
            ack_d      <= 1'b0;
        end else begin
            track_prev <= track;
            ack_d      <= sd_ack;
            if (track != track_prev)
                settle_cnt <= '0;
            else if (!settled)
                settle_cnt <= settle_cnt + 1'b1;
            if (settled)
                target <= track_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sec        <= 5'd0;
            cur_track  <= 6'd0;
            load_track <= 6'd0;
            dirty      <= 1'b0;
            mount_pend <= 1'b0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sd_lba     <= 32'd0;
        end else begin
            state      <= state_n;
            sec        <= sec_n;
            cur_track  <= cur_track_n;
            load_track <= load_track_n;
            dirty      <= dirty_n;
            mount_pend <= mount_pend_n;
            sd_rd      <= sd_rd_n;
            sd_wr      <= sd_wr_n;
            sd_lba     <= sd_lba_n;
        end
    end

    // Aborts (mount, image removal) only take effect on an ack fall so a started block always finishes.
    always_comb begin
        state_n      = state;
        sec_n        = sec;
        cur_track_n  = cur_track;
        load_track_n = load_track;
        dirty_n      = dirty;
        mount_pend_n = mount_pend | img_mounted;
        if (state == IDLE && buf_we && !img_readonly && cur_track != 6'd0)
            dirty_n = 1'b1;

        case (state)
            IDLE: begin
                sec_n = 5'd0;
                if (mount_pend || !img_present) begin
                    cur_track_n  = 6'd0;
                    dirty_n      = 1'b0;
                    mount_pend_n = img_mounted;
                end else if (settled && target != cur_track && !img_mounted) begin
                    if (dirty && !img_readonly) begin
                        state_n = FLUSH_REQ;
                    end else if (target_ok) begin
                        load_track_n = target;
                        cur_track_n  = 6'd0;
                        dirty_n      = 1'b0;
                        state_n      = LOAD_REQ;
                    end else begin
                        cur_track_n = 6'd0;
                        dirty_n     = 1'b0;
                    end
                end
            end
            FLUSH_REQ: begin
                if (!img_present) begin
                    state_n     = IDLE;
                    cur_track_n = 6'd0;
                    dirty_n     = 1'b0;
                end else if (sd_ack) begin
                    state_n = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (ack_fall) begin
                    if (abort) begin
                        state_n      = IDLE;
                        cur_track_n  = 6'd0;
                        dirty_n      = 1'b0;
                        sec_n        = 5'd0;
                        mount_pend_n = 1'b0;
                    end else if (sec == nsec(cur_track) - 5'd1) begin
                        dirty_n     = 1'b0;
                        cur_track_n = 6'd0;
                        sec_n       = 5'd0;
                        if (target_ok) begin
                            load_track_n = target;
                            state_n      = LOAD_REQ;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        sec_n   = sec + 5'd1;
                        state_n = FLUSH_REQ;
                    end
                end
            end
            LOAD_REQ: begin
                if (!img_present) begin
                    state_n     = IDLE;
                    cur_track_n = 6'd0;
                    dirty_n     = 1'b0;
                end else if (sd_ack) begin
                    state_n = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (ack_fall) begin
                    if (abort) begin
                        state_n      = IDLE;
                        cur_track_n  = 6'd0;
                        dirty_n      = 1'b0;
                        sec_n        = 5'd0;
                        mount_pend_n = 1'b0;
                    end else if (sec == nsec(load_track) - 5'd1) begin
                        cur_track_n = load_track;
                        sec_n       = 5'd0;
                        state_n     = IDLE;
                    end else if (settled && target != load_track) begin
                        sec_n = 5'd0;
                        if (target_ok) begin
                            load_track_n = target;
                            state_n      = LOAD_REQ;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        sec_n   = sec + 5'd1;
                        state_n = LOAD_REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        sd_rd_n  = (state_n == LOAD_REQ);
        sd_wr_n  = (state_n == FLUSH_REQ);
        sd_lba_n = sd_lba;
        if (state_n == LOAD_REQ)
            sd_lba_n = base_lba(load_track_n) + {27'd0, sec_n};
        else if (state_n == FLUSH_REQ)
            sd_lba_n = base_lba(cur_track_n) + {27'd0, sec_n};
    end
endmodule

// File: tb/tb_c1541_track_sched.sv
// tb_c1541_track_sched: directed scenarios against an SD responder that logs every
// block request; each scenario compares the logged sequence to hand-computed LBAs.
module tb_c1541_track_sched;
    localparam int SETTLE_CYC = 16;

    logic        clk;
    logic        reset;
    logic        img_mounted;
    logic        img_present;
    logic        img_readonly;
    logic [5:0]  track;
    logic        buf_we;
    logic        busy;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [5:0]  cur_track;

    int checks = 0;
    int errors = 0;
    int overlap_err = 0;
    int stable_err = 0;

    int unsigned log_lba[$];
    bit          log_wr[$];
    int unsigned exp_lba[$];
    bit          exp_wr[$];

    int          stall_at = 0;
    bit          stall_release = 0;
    bit          in_stall = 0;
    logic [31:0] lba0;
    logic        wr0;

    c1541_track_sched dut (
        .clk         (clk),
        .reset       (reset),
        .img_mounted (img_mounted),
        .img_present (img_present),
        .img_readonly(img_readonly),
        .track       (track),
        .buf_we      (buf_we),
        .busy        (busy),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .cur_track   (cur_track)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SD responder: logs each request, holds it a few cycles (or while stalled), then pulses ack
    initial begin
        sd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if ((sd_rd || sd_wr) && !sd_ack && !reset) begin
                lba0 = sd_lba;
                wr0  = sd_wr;
                log_lba.push_back(lba0);
                log_wr.push_back(wr0);
                repeat (2) begin
                    @(negedge clk);
                    if (sd_lba !== lba0 || sd_wr !== wr0 || sd_rd !== !wr0) stable_err++;
                end
                while (stall_at != 0 && log_lba.size() == stall_at && !stall_release) begin
                    in_stall = 1'b1;
                    @(negedge clk);
                    if (sd_lba !== lba0 || sd_wr !== wr0 || sd_rd !== !wr0) stable_err++;
                end
                in_stall = 1'b0;
                sd_ack = 1'b1;
                repeat (2) @(negedge clk);
                sd_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sd_rd === 1'b1 && sd_wr === 1'b1) overlap_err++;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_range(input int unsigned start, input int n, input bit wr);
        for (int i = 0; i < n; i++) begin
            exp_lba.push_back(start + i);
            exp_wr.push_back(wr);
        end
    endtask

    task automatic clear_logs();
        log_lba.delete();
        log_wr.delete();
        exp_lba.delete();
        exp_wr.delete();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        repeat (SETTLE_CYC + 4) @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            if (!busy && !sd_rd && !sd_wr && !sd_ack) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_stall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_stall) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        img_mounted  = 1'b0;
        img_present  = 1'b1;
        img_readonly = 1'b0;
        track        = 6'd1;
        buf_we       = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (sd_rd !== 1'b0)      begin errors++; $display("[TB] FAIL reset sd_rd: got %b, want 0", sd_rd); end
        if (sd_wr !== 1'b0)      begin errors++; $display("[TB] FAIL reset sd_wr: got %b, want 0", sd_wr); end
        if (sd_lba !== 32'd0)    begin errors++; $display("[TB] FAIL reset sd_lba: got %0d, want 0", sd_lba); end
        if (busy !== 1'b1)       begin errors++; $display("[TB] FAIL reset busy: got %b, want 1", busy); end
        if (cur_track !== 6'd0)  begin errors++; $display("[TB] FAIL reset cur_track: got %0d, want 0", cur_track); end
        clear_logs();
        reset = 1'b0;
    endtask

    task automatic test_initial_load();
        bit ok;
        push_range(0, 21, 1'b0);
        wait_idle(2000, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL load1 timeout: busy=%b, want idle", busy); end
        checks++;
        if (log_lba.size() !== exp_lba.size()) begin
            errors++; $display("[TB] FAIL load1 count: got %0d, want %0d", log_lba.size(), exp_lba.size());
        end
        for (int i = 0; i < exp_lba.size() && i < log_lba.size(); i++) begin
            checks++;
            if (log_lba[i] !== exp_lba[i] || log_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("[TB] FAIL load1[%0d]: got lba=%0d wr=%0b, want lba=%0d wr=%0b", i, log_lba[i], log_wr[i], exp_lba[i], exp_wr[i]);
            end
        end
        checks += 2;
        if (cur_track !== 6'd1) begin errors++; $display("[TB] FAIL load1 cur_track: got %0d, want 1", cur_track); end
        if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL load1 busy: got %b, want 0", busy); end
    endtask

    task automatic test_track_loads();
        int          trk[3]   = '{18, 35, 40};
        int unsigned start[3] = '{357, 666, 751};
        int          cnt[3]   = '{19, 17, 17};
        bit ok;
        for (int k = 0; k < 3; k++) begin
            clear_logs();
            push_range(start[k], cnt[k], 1'b0);
            track = 6'(trk[k]);
            wait_idle(2000, ok);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL load%0d timeout: busy=%b, want idle", trk[k], busy); end
            checks++;
            if (log_lba.size() !== exp_lba.size()) begin
                errors++; $display("[TB] FAIL load%0d count: got %0d, want %0d", trk[k], log_lba.size(), exp_lba.size());
            end
            for (int i = 0; i < exp_lba.size() && i < log_lba.size(); i++) begin
                checks++;
                if (log_lba[i] !== exp_lba[i] || log_wr[i] !== exp_wr[i]) begin
                    errors++;
                    $display("[TB] FAIL load%0d[%0d]: got lba=%0d wr=%0b, want lba=%0d wr=%0b", trk[k], i, log_lba[i], log_wr[i], exp_lba[i], exp_wr[i]);
                end
            end
            checks++;
            if (cur_track !== 6'(trk[k])) begin
                errors++; $display("[TB] FAIL load%0d cur_track: got %0d, want %0d", trk[k], cur_track, trk[k]);
            end
        end
    endtask

    task automatic test_flush();
        int          to_trk[3] = '{2, 3, 4};
        int unsigned rd_st[3]  = '{21, 42, 63};
        bit          we[3]     = '{1'b1, 1'b0, 1'b1};
        bit          ro[3]     = '{1'b0, 1'b0, 1'b1};
        bit ok;
        track = 6'd1;
        wait_idle(2000, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL flush setup timeout: busy=%b, want idle", busy); end
        for (int k = 0; k < 3; k++) begin
            clear_logs();
            img_readonly = ro[k];
            if (we[k]) begin
                buf_we = 1'b1;
                @(negedge clk);
                buf_we = 1'b0;
                @(negedge clk);
            end
            // a write-back happens only when the buffer was modified and the image is writable
            if (we[k] && !ro[k]) push_range(rd_st[k] - 21, 21, 1'b1);
            push_range(rd_st[k], 21, 1'b0);
            track = 6'(to_trk[k]);
            wait_idle(3000, ok);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL flush%0d timeout: busy=%b, want idle", k, busy); end
            checks++;
            if (log_lba.size() !== exp_lba.size()) begin
                errors++; $display("[TB] FAIL flush%0d count: got %0d, want %0d", k, log_lba.size(), exp_lba.size());
            end
            for (int i = 0; i < exp_lba.size() && i < log_lba.size(); i++) begin
                checks++;
                if (log_lba[i] !== exp_lba[i] || log_wr[i] !== exp_wr[i]) begin
                    errors++;
                    $display("[TB] FAIL flush%0d[%0d]: got lba=%0d wr=%0b, want lba=%0d wr=%0b", k, i, log_lba[i], log_wr[i], exp_lba[i], exp_wr[i]);
                end
            end
            checks++;
            if (cur_track !== 6'(to_trk[k])) begin
                errors++; $display("[TB] FAIL flush%0d cur_track: got %0d, want %0d", k, cur_track, to_trk[k]);
            end
        end
        img_readonly = 1'b0;
    endtask

    task automatic test_load_restart();
        bit ok;
        track = 6'd5;
        wait_idle(2000, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL restart setup timeout: busy=%b, want idle", busy); end
        clear_logs();
        push_range(105, 3, 1'b0);
        push_range(126, 21, 1'b0);
        stall_release = 1'b0;
        stall_at = 3;
        track = 6'd6;
        wait_stall(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL restart stall: stall not reached, want third read"); end
        track = 6'd7;
        repeat (SETTLE_CYC + 10) @(negedge clk);
        checks += 2;
        if (cur_track !== 6'd0) begin errors++; $display("[TB] FAIL restart mid cur_track: got %0d, want 0", cur_track); end
        if (busy !== 1'b1)      begin errors++; $display("[TB] FAIL restart mid busy: got %b, want 1", busy); end
        stall_release = 1'b1;
        wait_idle(2000, ok);
        stall_at = 0;
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL restart timeout: busy=%b, want idle", busy); end
        checks++;
        if (log_lba.size() !== exp_lba.size()) begin
            errors++; $display("[TB] FAIL restart count: got %0d, want %0d", log_lba.size(), exp_lba.size());
        end
        for (int i = 0; i < exp_lba.size() && i < log_lba.size(); i++) begin
            checks++;
            if (log_lba[i] !== exp_lba[i] || log_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("[TB] FAIL restart[%0d]: got lba=%0d wr=%0b, want lba=%0d wr=%0b", i, log_lba[i], log_wr[i], exp_lba[i], exp_wr[i]);
            end
        end
        checks++;
        if (cur_track !== 6'd7) begin errors++; $display("[TB] FAIL restart cur_track: got %0d, want 7", cur_track); end
    endtask

    task automatic test_track_toggle();
        int req_seen = 0;
        int busy_seen = 0;
        for (int k = 0; k < 12; k++) begin
            track = (k % 2 == 0) ? 6'd8 : 6'd7;
            repeat (10) begin
                @(negedge clk);
                if (sd_rd || sd_wr) req_seen++;
                if (busy) busy_seen++;
            end
        end
        track = 6'd7;
        repeat (SETTLE_CYC + 10) begin
            @(negedge clk);
            if (sd_rd || sd_wr) req_seen++;
            if (busy) busy_seen++;
        end
        checks += 3;
        if (req_seen !== 0)     begin errors++; $display("[TB] FAIL toggle requests: got %0d cycles, want 0", req_seen); end
        if (busy_seen !== 0)    begin errors++; $display("[TB] FAIL toggle busy: got %0d cycles, want 0", busy_seen); end
        if (cur_track !== 6'd7) begin errors++; $display("[TB] FAIL toggle cur_track: got %0d, want 7", cur_track); end
    endtask

    task automatic test_mount();
        bit ok;
        clear_logs();
        push_range(42, 2, 1'b0);
        push_range(42, 21, 1'b0);
        stall_release = 1'b0;
        stall_at = 2;
        track = 6'd3;
        wait_stall(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL mount stall: stall not reached, want second read"); end
        img_mounted = 1'b1;
        @(negedge clk);
        img_mounted = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (cur_track !== 6'd0) begin errors++; $display("[TB] FAIL mount mid cur_track: got %0d, want 0", cur_track); end
        stall_release = 1'b1;
        wait_idle(2000, ok);
        stall_at = 0;
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL mount timeout: busy=%b, want idle", busy); end
        checks++;
        if (log_lba.size() !== exp_lba.size()) begin
            errors++; $display("[TB] FAIL mount count: got %0d, want %0d", log_lba.size(), exp_lba.size());
        end
        for (int i = 0; i < exp_lba.size() && i < log_lba.size(); i++) begin
            checks++;
            if (log_lba[i] !== exp_lba[i] || log_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("[TB] FAIL mount[%0d]: got lba=%0d wr=%0b, want lba=%0d wr=%0b", i, log_lba[i], log_wr[i], exp_lba[i], exp_wr[i]);
            end
        end
        checks += 2;
        if (cur_track !== 6'd3) begin errors++; $display("[TB] FAIL mount cur_track: got %0d, want 3", cur_track); end
        if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL mount busy: got %b, want 0", busy); end
    endtask

    task automatic test_invalid_track();
        int bad[2] = '{41, 0};
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            track = 6'(bad[k]);
            repeat (SETTLE_CYC + 40) @(negedge clk);
            checks += 3;
            if (log_lba.size() !== 0) begin
                errors++; $display("[TB] FAIL invalid%0d requests: got %0d, want 0", bad[k], log_lba.size());
            end
            if (cur_track !== 6'd0) begin errors++; $display("[TB] FAIL invalid%0d cur_track: got %0d, want 0", bad[k], cur_track); end
            if (busy !== 1'b1)      begin errors++; $display("[TB] FAIL invalid%0d busy: got %b, want 1", bad[k], busy); end
        end
    endtask

    task automatic test_protocol();
        checks += 2;
        if (overlap_err !== 0) begin errors++; $display("[TB] FAIL rd_wr overlap: got %0d cycles, want 0", overlap_err); end
        if (stable_err !== 0)  begin errors++; $display("[TB] FAIL request hold: got %0d unstable cycles, want 0", stable_err); end
    endtask

    initial begin
        test_reset();
        test_initial_load();
        test_track_loads();
        test_flush();
        test_load_restart();
        test_track_toggle();
        test_mount();
        test_invalid_track();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
